// File: rtl/pe_pkg.sv
// Shared constants and types for the PE operand feeder.
package pe_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DIM    = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned GROUP  = 3;

    // addr[DIM-1] is most significant, so a plain unsigned compare orders coordinates
    typedef logic [DIM-1:0][ADDR_W-1:0] coord_t;

    typedef struct packed {
        coord_t              coord;
        logic [DATA_W-1:0]   w;
        logic [DATA_W-1:0]   ia;
        logic                last;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT} feeder_state_t;

endpackage

// File: rtl/pe_feeder_fifo.sv
// Input FIFO for pe_feeder; first-word-fall-through read, push and pop allowed together when full.
module pe_feeder_fifo
    import pe_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_data,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_data,
    output logic               o_full,
    output logic               o_empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
    logic               do_push, do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);
    assign o_data  = mem[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr_q[PTR_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/pe_feeder.sv
// Packs buffered entries into groups of three and hands them to the reducer one group at a time.
// Optional coordinate-order checker: define PE_FEEDER_ORDER_CHK_EN.
module pe_feeder
    import pe_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic [DIM*ADDR_W-1:0]                i_addr,
    input  logic [DATA_W-1:0]                    i_w,
    input  logic [DATA_W-1:0]                    i_ia,
    input  logic                                 i_last,
    output logic                                 o_start,
    output logic [GROUP-1:0][DIM*ADDR_W-1:0]     o_addr,
    output logic [GROUP-1:0][DATA_W-1:0]         o_w,
    output logic [GROUP-1:0][DATA_W-1:0]         o_ia,
    input  logic                                 i_finish,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic [15:0]                          o_grp_cnt,
    output logic                                 o_order_err
);

    feeder_state_t state_q;
    logic [1:0]    slot_q;
    logic          grp_last_q;
    logic          fifo_full, fifo_empty, push, pop;
    entry_t        wr_entry, rd_entry;

    assign wr_entry = {i_addr, i_w, i_ia, i_last};
    assign o_ready  = !fifo_full;
    assign push     = i_valid && o_ready;
    assign pop      = (state_q == S_FILL) && !fifo_empty;
    assign o_busy   = (state_q != S_IDLE) || !fifo_empty;

    pe_feeder_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  (wr_entry),
        .i_pop   (pop),
        .o_data  (rd_entry),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            grp_last_q <= 1'b0;
            o_start    <= 1'b0;
            o_done     <= 1'b0;
            o_grp_cnt  <= '0;
            o_addr     <= '0;
            o_w        <= '0;
            o_ia       <= '0;
        end else begin
            o_start <= 1'b0;
            o_done  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= S_FILL;
                        slot_q  <= '0;
                    end
                end
                S_FILL: begin
                    if (!fifo_empty) begin
                        // A last entry pads every later slot with its own coordinate and zero data
                        for (int j = 0; j < GROUP; j++) begin
                            if (j == int'(slot_q)) begin
                                o_addr[j] <= rd_entry.coord;
                                o_w[j]    <= rd_entry.w;
                                o_ia[j]   <= rd_entry.ia;
                            end else if (j > int'(slot_q) && rd_entry.last) begin
                                o_addr[j] <= rd_entry.coord;
                                o_w[j]    <= '0;
                                o_ia[j]   <= '0;
                            end
                        end
                        if (rd_entry.last || slot_q == 2'(GROUP - 1)) begin
                            state_q    <= S_ISSUE;
                            o_start    <= 1'b1;
                            grp_last_q <= rd_entry.last;
                        end else begin
                            slot_q <= slot_q + 2'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    o_grp_cnt <= o_grp_cnt + 16'd1;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_finish) begin
                        o_done  <= grp_last_q;
                        slot_q  <= '0;
                        state_q <= (!fifo_empty && !grp_last_q) ? S_FILL : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef PE_FEEDER_ORDER_CHK_EN
    coord_t prev_q;
    logic   have_prev_q, err_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (push) begin
            if (have_prev_q && (coord_t'(i_addr) < prev_q)) err_q <= 1'b1;
            prev_q      <= i_addr;
            have_prev_q <= !i_last;
        end
    end

    assign o_order_err = err_q;
`else
    assign o_order_err = 1'b0;
`endif

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, input FIFO entries (power of two, >=2).
REQ-002 Port: i_clk  in  1  single clock; all logic is rising-edge.
REQ-003 Port: i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: i_valid  in  1  input entry valid.
REQ-005 Port: o_ready  out  1  FIFO can accept an entry.
REQ-006 Port: i_addr  in  3x7 packed  entry coordinate.
REQ-007 Port: i_w  in  16  entry weight, unsigned.
REQ-008 Port: i_ia  in  16  entry activation, unsigned.
REQ-009 Port: i_last  in  1  entry is last of stream.
REQ-010 Port: o_start  out  1  one-cycle group-issue pulse to the reducer.
REQ-011 Port: o_addr  out  3 x (3x7)  slot coordinates, slot 0 oldest.
REQ-012 Port: o_w, o_ia  out  3 x 16 each  slot operands.
REQ-013 Port: i_finish  in  1  reducer group-complete pulse.
REQ-014 Port: o_busy  out  1  a group is outstanding or entries are buffered.
REQ-015 Port: o_done  out  1  one-cycle pulse when the stream's final group completes.
REQ-016 Port: o_grp_cnt  out  16  groups issued since reset, wraps.
REQ-017 Port: o_order_err  out  1  sticky address-order error (see Configuration).

Function
REQ-018 Entry accepted when i_valid && o_ready; o_ready = FIFO not full; push and pop in the same cycle are legal when full and leave occupancy unchanged.
REQ-019 FSM states: S_IDLE, S_FILL, S_ISSUE, S_WAIT; reset state S_IDLE.
REQ-020 S_IDLE->S_FILL when FIFO is non-empty; S_FILL pops one entry per cycle into slot k=0,1,2 in order.
REQ-021 S_FILL->S_ISSUE when slot 2 is loaded or a popped entry carries i_last.
REQ-022 Partial group (last entry in slot 0 or 1): each unused slot gets the coordinate of the last filled slot, w=0, ia=0.
REQ-023 S_ISSUE asserts o_start for exactly one cycle, increments o_grp_cnt, then enters S_WAIT.
REQ-024 o_addr/o_w/o_ia are registered and held stable from the S_ISSUE cycle until the cycle after i_finish.
REQ-025 S_WAIT->S_FILL on i_finish if the FIFO is non-empty and the group was not last; else ->S_IDLE.
REQ-026 o_done pulses in the cycle after i_finish for a group containing i_last.
REQ-027 i_finish outside S_WAIT is ignored.
REQ-028 No new o_start before i_finish of the previous group: at most one group is outstanding.
REQ-029 o_busy = (state != S_IDLE) || FIFO non-empty.

Reset
REQ-030 Asserting i_rst_n low at any time immediately clears state, FIFO pointers, slots, o_grp_cnt, and o_order_err to 0 and forces o_start=0, o_done=0.
REQ-031 Reset values: o_ready=1, o_busy=0; all slot outputs 0; any outstanding group is abandoned.

Configuration
REQ-032 Macro PE_FEEDER_ORDER_CHK_EN defined: o_order_err is set when an accepted coordinate {addr[2],addr[1],addr[0]} is less than the previous accepted coordinate of the same stream; it stays set until reset and does not stall the data path.
REQ-033 Macro undefined: no check logic is built; o_order_err is tied to 0.

Structure
REQ-034 Shared package pe_pkg holds ADDR_W=7, DIM=3, DATA_W=16, GROUP=3, the coordinate typedef, and the feeder state enum.
REQ-035 The FIFO is a separate sub-module pe_feeder_fifo (FIFO_DEPTH entries of {coord, w, ia, last}).

Verification
REQ-036 Six entries, coords 1..6, w=ia=2, last on 6 -> two o_start pulses with slots {1,2,3},{4,5,6}; o_done after the 2nd i_finish; o_grp_cnt=2.
REQ-037 Four entries, last on coord 9 -> second group is {9,9,9} with w/ia {x,0,0}; slots 1 and 2 are zero.
REQ-038 Hold i_finish low for 20 cycles -> no second o_start; outputs stable; FIFO fills and o_ready=0 at FIFO_DEPTH entries.
REQ-039 Assert reset in S_WAIT -> the same cycle shows o_start=0, o_busy=0, o_grp_cnt=0; a following stream issues normally.
REQ-040 Macro defined, coords 5 then 3 -> o_order_err=1 and remains 1; macro undefined -> o_order_err stays 0.
REQ-041 Stray i_finish in S_IDLE -> no state change, no o_done.
